// File: rtl/dma_pkg.sv
// Shared types and constants for the memory-to-memory DMA engine.
// Optional interrupt support is selected with the DMA_IRQ_EN macro.
package dma_pkg;

   // Initiator-side sequencing: one read then one write per word
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } dma_state_e;

   // Register word offsets (address bits [3:2])
   localparam logic [1:0] REG_SRC  = 2'd0;
   localparam logic [1:0] REG_DST  = 2'd1;
   localparam logic [1:0] REG_LEN  = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   // CTRL bit positions
   localparam int CTRL_START = 0;
   localparam int CTRL_BUSY  = 1;
   localparam int CTRL_DONE  = 2;
   localparam int CTRL_FAULT = 3;
   localparam int CTRL_IE    = 4;

endpackage

// File: rtl/dma_regs.sv
// Responder-side register file of the DMA engine: SRC/DST/LEN, DONE/FAULT
// W1C status, START pulse generation and, with DMA_IRQ_EN, IE and irq_out.
module dma_regs
   import dma_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        sel_in,
   input  logic [1:0]  reg_addr_in,
   input  logic        wr_en_in,
   input  logic [31:0] wdata_in,
   input  logic        busy_in,
   input  logic        set_done_in,
   input  logic        set_fault_in,
   output logic        start_out,
   output logic [31:0] src_out,
   output logic [31:0] dst_out,
   output logic [15:0] len_out,
   output logic [31:0] rdata_out
`ifdef DMA_IRQ_EN
   , output logic      irq_out
`endif
);

   logic [31:0] src_q, src_d;
   logic [31:0] dst_q, dst_d;
   logic [15:0] len_q, len_d;
   logic        done_q, done_d;
   logic        fault_q, fault_d;
   logic        reg_wr;
   logic [31:0] ctrl_val;
`ifdef DMA_IRQ_EN
   logic        ie_q, ie_d;
   logic        irq_q, irq_d;
`endif

   assign reg_wr    = sel_in & wr_en_in;
   assign start_out = reg_wr && (reg_addr_in == REG_CTRL) && wdata_in[CTRL_START] && !busy_in;
   assign src_out   = src_q;
   assign dst_out   = dst_q;
   assign len_out   = len_q;
`ifdef DMA_IRQ_EN
   assign irq_out   = irq_q;
`endif

   // Next-state of the register file; status sets from the engine beat W1C clears
   always_comb begin
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      done_d  = done_q;
      fault_d = fault_q;
`ifdef DMA_IRQ_EN
      ie_d    = ie_q;
`endif
      if (reg_wr && !busy_in) begin
         case (reg_addr_in)
            REG_SRC: src_d = {wdata_in[31:2], 2'b00};
            REG_DST: dst_d = {wdata_in[31:2], 2'b00};
            REG_LEN: len_d = wdata_in[15:0];
            default: ;
         endcase
      end
      if (reg_wr && (reg_addr_in == REG_CTRL)) begin
         if (wdata_in[CTRL_DONE])  done_d  = 1'b0;
         if (wdata_in[CTRL_FAULT]) fault_d = 1'b0;
`ifdef DMA_IRQ_EN
         ie_d = wdata_in[CTRL_IE];
`endif
      end
      if (start_out) begin
         done_d  = 1'b0;
         fault_d = 1'b0;
      end
      if (set_done_in)  done_d  = 1'b1;
      if (set_fault_in) fault_d = 1'b1;
`ifdef DMA_IRQ_EN
      // Computed from next values so the interrupt rises together with DONE/FAULT
      irq_d = ie_d & (done_d | fault_d);
`endif
   end

   // Register file state with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
`ifdef DMA_IRQ_EN
         ie_q    <= 1'b0;
         irq_q   <= 1'b0;
`endif
      end else begin
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         done_q  <= done_d;
         fault_q <= fault_d;
`ifdef DMA_IRQ_EN
         ie_q    <= ie_d;
         irq_q   <= irq_d;
`endif
      end
   end

   // Zero-wait read mux, forced to 0 when not selected so it can be OR-combined
   always_comb begin
      ctrl_val             = '0;
      ctrl_val[CTRL_BUSY]  = busy_in;
      ctrl_val[CTRL_DONE]  = done_q;
      ctrl_val[CTRL_FAULT] = fault_q;
`ifdef DMA_IRQ_EN
      ctrl_val[CTRL_IE]    = ie_q;
`endif
      rdata_out = '0;
      if (sel_in) begin
         case (reg_addr_in)
            REG_SRC:  rdata_out = src_q;
            REG_DST:  rdata_out = dst_q;
            REG_LEN:  rdata_out = {16'h0000, len_q};
            default:  rdata_out = ctrl_val;
         endcase
      end
   end

endmodule

// File: rtl/dma_engine.sv
// Word-granular memory-to-memory copy engine: responder register window plus
// an initiator port issuing alternating read/write transfers.
// Optional macro DMA_IRQ_EN adds CTRL.IE and the irq_out port.
module dma_engine
   import dma_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address_in,
   input  logic        sel_in,
   input  logic        read_in,
   output logic [31:0] read_value_out,
   input  logic [3:0]  write_mask_in,
   input  logic [31:0] write_value_in,
   output logic        ready_out,
   output logic [31:0] m_address_out,
   output logic        m_read_out,
   output logic        m_write_out,
   input  logic [31:0] m_read_value_in,
   output logic [3:0]  m_write_mask_out,
   output logic [31:0] m_write_value_out,
   input  logic        m_ready_in,
   input  logic        m_fault_in
`ifdef DMA_IRQ_EN
   , output logic      irq_out
`endif
);

   dma_state_e  state_q, state_d;
   logic [31:0] src_q, src_d;
   logic [31:0] dst_q, dst_d;
   logic [15:0] rem_q, rem_d;
   logic [31:0] data_q, data_d;
   logic        busy;
   logic        start;
   logic        set_done;
   logic        set_fault;
   logic [31:0] reg_src;
   logic [31:0] reg_dst;
   logic [15:0] reg_len;
   logic        unused_bits;

   // Reads are combinational and undecoded bits carry no meaning
   assign unused_bits = ^{address_in[31:4], address_in[1:0], read_in, write_mask_in[3:1]};

   assign busy      = (state_q != IDLE);
   assign ready_out = sel_in;

   dma_regs u_regs (
      .clk          (clk),
      .reset        (reset),
      .sel_in       (sel_in),
      .reg_addr_in  (address_in[3:2]),
      .wr_en_in     (write_mask_in[0]),
      .wdata_in     (write_value_in),
      .busy_in      (busy),
      .set_done_in  (set_done),
      .set_fault_in (set_fault),
      .start_out    (start),
      .src_out      (reg_src),
      .dst_out      (reg_dst),
      .len_out      (reg_len),
      .rdata_out    (read_value_out)
`ifdef DMA_IRQ_EN
      , .irq_out    (irq_out)
`endif
   );

   // Requests are pure functions of the current state so they stay stable while waiting
   assign m_read_out        = (state_q == READ);
   assign m_write_out       = (state_q == WRITE);
   assign m_address_out     = m_read_out ? src_q : (m_write_out ? dst_q : 32'h0);
   assign m_write_mask_out  = m_write_out ? 4'hF : 4'h0;
   assign m_write_value_out = m_write_out ? data_q : 32'h0;

   // Next-state and working-counter updates for the copy sequence
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      rem_d     = rem_q;
      data_d    = data_q;
      set_done  = 1'b0;
      set_fault = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (reg_len == 16'h0000) begin
                  set_done = 1'b1;
               end else begin
                  state_d = READ;
                  src_d   = reg_src;
                  dst_d   = reg_dst;
                  rem_d   = reg_len;
               end
            end
         end
         READ: begin
            if (m_ready_in) begin
               if (m_fault_in) begin
                  state_d   = IDLE;
                  set_fault = 1'b1;
               end else begin
                  data_d  = m_read_value_in;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            if (m_ready_in) begin
               if (m_fault_in) begin
                  state_d   = IDLE;
                  set_fault = 1'b1;
               end else begin
                  src_d = src_q + 32'd4;
                  dst_d = dst_q + 32'd4;
                  rem_d = rem_q - 16'd1;
                  if (rem_q == 16'd1) begin
                     state_d  = IDLE;
                     set_done = 1'b1;
                  end else begin
                     state_d = READ;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and working counters; reset abandons any partial copy
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_dma_engine.sv
// Directed self-checking bench for dma_engine with a behavioural bus responder.
// Build with DMA_IRQ_EN defined to also exercise the interrupt path.
module tb_dma_engine;

   logic        clk;
   logic        reset;
   logic [31:0] address_in;
   logic        sel_in;
   logic        read_in;
   logic [31:0] read_value_out;
   logic [3:0]  write_mask_in;
   logic [31:0] write_value_in;
   logic        ready_out;
   logic [31:0] m_address_out;
   logic        m_read_out;
   logic        m_write_out;
   logic [31:0] m_read_value_in;
   logic [3:0]  m_write_mask_out;
   logic [31:0] m_write_value_out;
   logic        m_ready_in;
   logic        m_fault_in;
`ifdef DMA_IRQ_EN
   logic        irq_out;
`endif

   dma_engine dut (
      .clk               (clk),
      .reset             (reset),
      .address_in        (address_in),
      .sel_in            (sel_in),
      .read_in           (read_in),
      .read_value_out    (read_value_out),
      .write_mask_in     (write_mask_in),
      .write_value_in    (write_value_in),
      .ready_out         (ready_out),
      .m_address_out     (m_address_out),
      .m_read_out        (m_read_out),
      .m_write_out       (m_write_out),
      .m_read_value_in   (m_read_value_in),
      .m_write_mask_out  (m_write_mask_out),
      .m_write_value_out (m_write_value_out),
      .m_ready_in        (m_ready_in),
      .m_fault_in        (m_fault_in)
`ifdef DMA_IRQ_EN
      , .irq_out         (irq_out)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] mem [0:1023];
   logic [31:0] rd_log [0:7];
   int wait_cfg     = 0;
   int fault_read_n = 0;
   int reads_cnt    = 0;
   int writes_cnt   = 0;
   int req_seen     = 0;
   int both_high    = 0;
   int unstable     = 0;
   int mask_bad     = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-16s observed %h expected %h", tag, obs, exp);
   endtask

   // Combinational register read, done within the current low clock phase
   task automatic peek(input logic [3:0] a, output logic [31:0] v);
      address_in = {28'h0, a};
      sel_in     = 1'b1;
      read_in    = 1'b1;
      #1;
      v          = read_value_out;
      sel_in     = 1'b0;
      read_in    = 1'b0;
      address_in = 32'h0;
   endtask

   // Register write occupying exactly one clock edge; starts and ends at a negedge
   task automatic bus_write_m(input logic [3:0] a, input logic [31:0] v, input logic [3:0] m);
      address_in     = {28'h0, a};
      write_value_in = v;
      write_mask_in  = m;
      sel_in         = 1'b1;
      @(negedge clk);
      sel_in         = 1'b0;
      write_mask_in  = 4'h0;
      write_value_in = 32'h0;
      address_in     = 32'h0;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] v);
      bus_write_m(a, v, 4'hF);
   endtask

   // Cycles (negedges) until DONE or FAULT is seen; -1 on timeout
   task automatic wait_done(input int budget, output int cycles);
      logic [31:0] v;
      cycles = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         peek(4'hC, v);
         if (v[2] || v[3]) begin
            cycles = i;
            break;
         end
      end
   endtask

   // Bus responder: answers after wait_cfg waiting cycles, optionally faults a read
   initial begin
      int          wait_cnt;
      logic        pending;
      logic [31:0] p_addr, p_wv;
      logic        p_rd, p_wr;
      logic [3:0]  p_wm;
      wait_cnt = 0;
      pending  = 1'b0;
      p_addr = '0; p_wv = '0; p_rd = 1'b0; p_wr = 1'b0; p_wm = '0;
      m_ready_in      = 1'b0;
      m_fault_in      = 1'b0;
      m_read_value_in = 32'h0;
      forever begin
         @(negedge clk);
         m_ready_in = 1'b0;
         m_fault_in = 1'b0;
         if (m_read_out && m_write_out) both_high++;
         if (m_read_out || m_write_out) begin
            req_seen++;
            if (pending && (m_address_out !== p_addr || m_read_out !== p_rd || m_write_out !== p_wr ||
                            m_write_value_out !== p_wv || m_write_mask_out !== p_wm))
               unstable++;
            if (wait_cnt == wait_cfg) begin
               m_ready_in = 1'b1;
               wait_cnt   = 0;
               pending    = 1'b0;
               if (m_read_out) begin
                  if (reads_cnt < 8) rd_log[reads_cnt] = m_address_out;
                  reads_cnt++;
                  m_read_value_in = mem[m_address_out[11:2]];
                  if (reads_cnt == fault_read_n) m_fault_in = 1'b1;
               end else begin
                  writes_cnt++;
                  if (m_write_mask_out !== 4'hF) mask_bad++;
                  mem[m_address_out[11:2]] = m_write_value_out;
               end
            end else begin
               wait_cnt++;
               pending = 1'b1;
               p_addr = m_address_out; p_wv = m_write_value_out;
               p_rd = m_read_out; p_wr = m_write_out; p_wm = m_write_mask_out;
            end
         end else begin
            wait_cnt = 0;
            pending  = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      int cyc;
      reset = 1'b0; sel_in = 1'b0; read_in = 1'b0; address_in = '0;
      write_mask_in = '0; write_value_in = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      for (int i = 0; i < 4; i++) mem[32'h40 + i] = 32'hA0 + i;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Reset state
      check("rst_m_read", {31'b0, m_read_out}, 32'h0);
      check("rst_m_write", {31'b0, m_write_out}, 32'h0);
      check("rst_m_addr", m_address_out, 32'h0);
      check("rst_m_mask", {28'b0, m_write_mask_out}, 32'h0);
      peek(4'h0, v); check("rst_src", v, 32'h0);
      peek(4'h8, v); check("rst_len", v, 32'h0);
      peek(4'hC, v); check("rst_ctrl", v, 32'h0);
`ifdef DMA_IRQ_EN
      check("rst_irq", {31'b0, irq_out}, 32'h0);
`endif

      // Register access: low bits forced, mask[0] gating, unselected read is 0
      bus_write(4'h0, 32'h0000_0107);
      peek(4'h0, v); check("src_lowbits", v, 32'h0000_0104);
      bus_write_m(4'h0, 32'h1234_5678, 4'hE);
      peek(4'h0, v); check("src_mask0", v, 32'h0000_0104);
      address_in = 32'h0; #1;
      check("rdata_unsel", read_value_out, 32'h0);
      check("ready_unsel", {31'b0, ready_out}, 32'h0);

      // Zero-wait LEN=4 copy
      bus_write(4'h0, 32'h100);
      bus_write(4'h4, 32'h200);
      bus_write(4'h8, 32'hFFFF_0004);
      peek(4'h8, v); check("len_hi_zero", v, 32'h4);
      bus_write(4'hC, 32'h1);
      check("t1_first_read", {31'b0, m_read_out}, 32'h1);
      check("t1_first_addr", m_address_out, 32'h100);
      wait_done(100, cyc); check("t1_cycles", cyc, 32'd8);
      peek(4'hC, v); check("t1_ctrl", v, 32'h4);
      for (int i = 0; i < 4; i++) check("t1_data", mem[32'h80 + i], 32'hA0 + i);

      // Same copy with two wait cycles per phase
      for (int i = 0; i < 4; i++) mem[32'h80 + i] = 32'h0;
      wait_cfg = 2;
      bus_write(4'hC, 32'h1);
      wait_done(200, cyc); check("t2_cycles", cyc, 32'd24);
      peek(4'hC, v); check("t2_ctrl", v, 32'h4);
      for (int i = 0; i < 4; i++) check("t2_data", mem[32'h80 + i], 32'hA0 + i);
      wait_cfg = 0;

      // LEN=0: DONE next cycle, bus untouched
      bus_write(4'hC, 32'h4);
      peek(4'hC, v); check("t3_cleared", v, 32'h0);
      bus_write(4'h8, 32'h0);
      req_seen = 0;
      bus_write(4'hC, 32'h1);
      peek(4'hC, v); check("t3_ctrl", v, 32'h4);
      repeat (4) @(negedge clk);
      check("t3_no_req", req_seen, 32'd0);

      // Fault on the second read of a LEN=3 copy
      bus_write(4'h4, 32'h300);
      bus_write(4'h8, 32'h3);
      reads_cnt = 0; writes_cnt = 0; fault_read_n = 2;
      bus_write(4'hC, 32'h1);
      wait_done(100, cyc); check("t4_cycles", cyc, 32'd3);
      peek(4'hC, v); check("t4_ctrl", v, 32'h8);
      check("t4_writes", writes_cnt, 32'd1);
      check("t4_word0", mem[32'hC0], 32'hA0);
      check("t4_word1", mem[32'hC1], 32'h0);
      peek(4'h8, v); check("t4_len", v, 32'h3);
      peek(4'h4, v); check("t4_dst", v, 32'h300);
      fault_read_n = 0;
      bus_write(4'hC, 32'h8);
      peek(4'hC, v); check("t4_w1c", v, 32'h0);

      // W1C of DONE in the same cycle DONE is set: set wins
      bus_write(4'h4, 32'h600);
      bus_write(4'h8, 32'h1);
      bus_write(4'hC, 32'h1);
      @(negedge clk);
      bus_write(4'hC, 32'h4);
      peek(4'hC, v); check("w1c_vs_set", v, 32'h4);

      // Address wrap, and writes during BUSY ignored
      wait_cfg = 1;
      mem[32'h3FF] = 32'hB0; mem[0] = 32'hB1;
      bus_write(4'h0, 32'hFFFF_FFFF);
      bus_write(4'h4, 32'h400);
      bus_write(4'h8, 32'h2);
      reads_cnt = 0;
      bus_write(4'hC, 32'h1);
      bus_write(4'h8, 32'h7);
      bus_write(4'h0, 32'h100);
      bus_write(4'hC, 32'h1);
      peek(4'h8, v); check("t5_len_busy", v, 32'h2);
      peek(4'h0, v); check("t5_src_busy", v, 32'hFFFF_FFFC);
      wait_done(100, cyc); check("t5_cycles", cyc, 32'd5);
      check("t5_rd0", rd_log[0], 32'hFFFF_FFFC);
      check("t5_rd1", rd_log[1], 32'h0);
      check("t5_data0", mem[32'h100], 32'hB0);
      check("t5_data1", mem[32'h101], 32'hB1);
      repeat (4) @(negedge clk);
      check("t5_reads", reads_cnt, 32'd2);
      peek(4'hC, v); check("t5_ctrl", v, 32'h4);
      wait_cfg = 0;

`ifdef DMA_IRQ_EN
      // Interrupt follows DONE and is dropped by its W1C
      bus_write(4'hC, 32'h1C);
      peek(4'hC, v); check("irq_ie_set", v, 32'h10);
      check("irq_idle", {31'b0, irq_out}, 32'h0);
      bus_write(4'h0, 32'h100);
      bus_write(4'h4, 32'h500);
      bus_write(4'h8, 32'h1);
      bus_write(4'hC, 32'h11);
      check("irq_busy0", {31'b0, irq_out}, 32'h0);
      @(negedge clk);
      check("irq_busy1", {31'b0, irq_out}, 32'h0);
      @(negedge clk);
      check("irq_done", {31'b0, irq_out}, 32'h1);
      peek(4'hC, v); check("irq_ctrl", v, 32'h14);
      bus_write(4'hC, 32'h14);
      check("irq_cleared", {31'b0, irq_out}, 32'h0);
      check("irq_data", mem[32'h140], 32'hA0);
`else
      bus_write(4'hC, 32'h1C);
      peek(4'hC, v); check("ie_absent", v, 32'h0);
`endif

      // Reset asserted mid-copy
      bus_write(4'h0, 32'h100);
      bus_write(4'h4, 32'h700);
      bus_write(4'h8, 32'h4);
      bus_write(4'hC, 32'h1);
      repeat (2) @(negedge clk);
      peek(4'hC, v); check("mid_busy", v[1:0], 32'h2);
      reset = 1'b0;
      @(negedge clk);
      check("mr_m_read", {31'b0, m_read_out}, 32'h0);
      check("mr_m_write", {31'b0, m_write_out}, 32'h0);
      check("mr_m_addr", m_address_out, 32'h0);
      check("mr_m_wval", m_write_value_out, 32'h0);
`ifdef DMA_IRQ_EN
      check("mr_irq", {31'b0, irq_out}, 32'h0);
`endif
      reset = 1'b1;
      peek(4'hC, v); check("mr_ctrl", v, 32'h0);
      peek(4'h0, v); check("mr_src", v, 32'h0);
      peek(4'h8, v); check("mr_len", v, 32'h0);

      // Protocol properties observed across the whole run
      check("both_high", both_high, 32'd0);
      check("req_unstable", unstable, 32'd0);
      check("wmask_bad", mask_bad, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
